// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: clock inhibit, request-to-send, then shifts one
// byte plus odd parity out on device-generated clock edges and checks the device ACK.
module ps2_tx #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int INHIBIT_US = 100,
   parameter int TIMEOUT_US = 15000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   inout  wire        ps2clk,
   inout  wire        ps2data,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_err
);

   localparam int INHIBIT_CYC = CLK_FREQ / 1_000_000 * INHIBIT_US;
   localparam int TIMEOUT_CYC = CLK_FREQ / 1_000_000 * TIMEOUT_US;
   localparam int MAX_CYC     = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
   localparam int CNT_W       = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      IDLE, INHIBIT, RTS, DATA, STOP, ACK, WAIT_IDLE
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [3:0]       bit_cnt, bit_cnt_n;
   logic [8:0]       shift, shift_n;
   logic             clk_oe, clk_oe_n;
   logic             data_oe, data_oe_n;
   logic             done_n, err_n, busy_n;
   logic             clk_p0, clk_p1, clk_p2;
   logic             dat_p0, dat_p1, dat_p2;
   logic             fall;

   // Open-drain: a line is either pulled low or left to the bus pullup
   assign ps2clk  = clk_oe  ? 1'b0 : 1'bz;
   assign ps2data = data_oe ? 1'b0 : 1'bz;

   assign fall = ~clk_p1 & clk_p2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_p0 <= 1'b1;
         clk_p1 <= 1'b1;
         clk_p2 <= 1'b1;
         dat_p0 <= 1'b1;
         dat_p1 <= 1'b1;
         dat_p2 <= 1'b1;
      end else begin
         clk_p0 <= ps2clk;
         clk_p1 <= clk_p0;
         clk_p2 <= clk_p1;
         dat_p0 <= ps2data;
         dat_p1 <= dat_p0;
         dat_p2 <= dat_p1;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_cnt_n = bit_cnt;
      shift_n   = shift;
      clk_oe_n  = clk_oe;
      data_oe_n = data_oe;
      done_n    = 1'b0;
      err_n     = 1'b0;
      case (state)
         IDLE: begin
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            if (tx_start && !tx_busy) begin
               shift_n  = {~^tx_data, tx_data};
               cnt_n    = '0;
               clk_oe_n = 1'b1;
               state_n  = INHIBIT;
            end
         end
         INHIBIT: begin
            cnt_n = cnt + 1'b1;
            if (cnt == INHIBIT_LAST) begin
               data_oe_n = 1'b1;
               state_n   = RTS;
            end
         end
         RTS: begin
            clk_oe_n  = 1'b0;
            bit_cnt_n = '0;
            cnt_n     = '0;
            state_n   = DATA;
         end
         DATA: begin
            if (fall) begin
               data_oe_n = ~shift[0];
               shift_n   = {1'b0, shift[8:1]};
               bit_cnt_n = bit_cnt + 1'b1;
               if (bit_cnt == 4'd8) state_n = STOP;
            end
         end
         STOP: begin
            if (fall) begin
               data_oe_n = 1'b0;
               state_n   = ACK;
            end
         end
         ACK: begin
            if (fall) begin
               if (dat_p2) begin
                  err_n     = 1'b1;
                  clk_oe_n  = 1'b0;
                  data_oe_n = 1'b0;
                  state_n   = IDLE;
               end else begin
                  state_n = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            if (clk_p2 && dat_p2) begin
               done_n  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      // Device-paced phases: every falling edge restarts the watchdog
      if (state inside {DATA, STOP, ACK, WAIT_IDLE}) begin
         if (fall) begin
            cnt_n = '0;
         end else if (cnt == TIMEOUT_LAST) begin
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            done_n    = 1'b0;
            err_n     = 1'b1;
            state_n   = IDLE;
         end else begin
            cnt_n = cnt + 1'b1;
         end
      end

      busy_n = (state_n != IDLE) | done_n | err_n;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         clk_oe  <= 1'b0;
         data_oe <= 1'b0;
         tx_busy <= 1'b0;
         tx_done <= 1'b0;
         tx_err  <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_cnt <= bit_cnt_n;
         clk_oe  <= clk_oe_n;
         data_oe <= data_oe_n;
         tx_busy <= busy_n;
         tx_done <= done_n;
         tx_err  <= err_n;
      end
   end

   always_ff @(posedge clk) begin
      shift <= shift_n;
   end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: pulled-up open-drain bus with a PS/2 device model that clocks
// at a 40-cycle period, captures the host frame and optionally acknowledges it.
module tb_ps2_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_busy, tx_done, tx_err;
   logic       dev_clk_low, dev_data_low;
   wire        ps2clk, ps2data;

   int tests = 0;
   int fails = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;

   typedef struct {
      int          n_inh;
      int          n_both;
      bit          rts_ok;
      logic [10:0] fr;
      bit          done_seen;
      logic        busy_at;
      logic        busy_after;
      int          ddelta;
      int          edelta;
   } obs_t;

   assign ps2clk  = dev_clk_low  ? 1'b0 : 1'bz;
   assign ps2data = dev_data_low ? 1'b0 : 1'bz;
   pullup (ps2clk);
   pullup (ps2data);

   ps2_tx #(
      .CLK_FREQ   (1_000_000),
      .INHIBIT_US (100),
      .TIMEOUT_US (500)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .ps2clk   (ps2clk),
      .ps2data  (ps2data),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done),
      .tx_err   (tx_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
      if (tx_err === 1'b1) err_cnt <= err_cnt + 1;
      if (tx_done === 1'b1 && tx_err === 1'b1) both_cnt <= both_cnt + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   // Frame as the device should see it: start 0, data LSB first, odd parity, stop 1
   function automatic logic [10:0] frame_of(input logic [7:0] d);
      int   ones;
      logic par;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
      return {1'b1, par, d, 1'b0};
   endfunction

   task automatic start_tx(input logic [7:0] d);
      @(negedge clk);
      tx_start = 1'b1;
      tx_data  = d;
      @(negedge clk);
      tx_start = 1'b0;
   endtask

   task automatic wait_rts(output int n_inh, output int n_both, output bit ok);
      int guard;
      n_inh = 0;
      n_both = 0;
      guard = 0;
      while (ps2clk === 1'b0 && ps2data === 1'b1 && guard < 1000) begin
         n_inh++;
         guard++;
         @(negedge clk);
      end
      while (ps2clk === 1'b0 && ps2data === 1'b0 && guard < 1000) begin
         n_both++;
         guard++;
         @(negedge clk);
      end
      ok = (ps2clk === 1'b1 && ps2data === 1'b0);
   endtask

   task automatic dev_frame(input bit ack, input int abort_after, output logic [10:0] fr);
      fr = '1;
      fr[0] = ps2data;
      for (int k = 1; k <= 11; k++) begin
         repeat (20) @(negedge clk);
         dev_clk_low = 1'b1;
         repeat (20) @(negedge clk);
         if (k <= 10) fr[k] = ps2data;
         dev_clk_low = 1'b0;
         if (k == abort_after) return;
         if (k == 10 && ack) dev_data_low = 1'b1;
         if (k == 11) dev_data_low = 1'b0;
      end
   endtask

   task automatic run_send(input logic [7:0] d, input bit ack, input bit inject, output obs_t o);
      int d0, e0, guard;
      d0 = done_cnt;
      e0 = err_cnt;
      start_tx(d);
      wait_rts(o.n_inh, o.n_both, o.rts_ok);
      fork
         dev_frame(ack, 0, o.fr);
         begin
            if (inject) begin
               repeat (150) @(negedge clk);
               tx_start = 1'b1;
               tx_data  = 8'h12;
               @(negedge clk);
               tx_start = 1'b0;
            end
         end
      join
      guard = 0;
      while (tx_done !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      o.done_seen = (tx_done === 1'b1);
      o.busy_at = tx_busy;
      @(negedge clk);
      o.busy_after = tx_busy;
      repeat (5) @(negedge clk);
      o.ddelta = done_cnt - d0;
      o.edelta = err_cnt - e0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tx_start = 1'b0;
      tx_data = 8'h00;
      dev_clk_low = 1'b0;
      dev_data_low = 1'b0;
      repeat (4) @(negedge clk);
      tests++;
      if (tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_err !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: got busy=%b done=%b err=%b, required 0 0 0", tx_busy, tx_done, tx_err);
      end
      tests++;
      if (ps2clk !== 1'b1 || ps2data !== 1'b1) begin
         fails++;
         $display("FAIL reset_lines: got clk=%b data=%b, required released (1 1)", ps2clk, ps2data);
      end
      reset = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_send_f4;
      obs_t o;
      run_send(8'hF4, 1'b1, 1'b0, o);
      tests++;
      if (o.n_inh != 100) begin
         fails++;
         $display("FAIL f4_inhibit_len: got %0d cycles, required 100", o.n_inh);
      end
      tests++;
      if (o.n_both != 1 || !o.rts_ok) begin
         fails++;
         $display("FAIL f4_rts: got overlap=%0d release_ok=%0d, required 1 1", o.n_both, o.rts_ok);
      end
      tests++;
      if (o.fr !== 11'b1_0_1111_0100_0) begin
         fails++;
         $display("FAIL f4_frame: got %b, required %b", o.fr, 11'b1_0_1111_0100_0);
      end
      tests++;
      if (!o.done_seen || o.ddelta != 1 || o.edelta != 0) begin
         fails++;
         $display("FAIL f4_done: got seen=%0d done=%0d err=%0d, required 1 1 0", o.done_seen, o.ddelta, o.edelta);
      end
      tests++;
      if (o.busy_at !== 1'b1 || o.busy_after !== 1'b0) begin
         fails++;
         $display("FAIL f4_busy_fall: got at_done=%b after=%b, required 1 0", o.busy_at, o.busy_after);
      end
   endtask

   task automatic test_parity;
      obs_t o;
      logic [7:0] vals [2];
      vals[0] = 8'h00;
      vals[1] = 8'hFF;
      for (int i = 0; i < 2; i++) begin
         run_send(vals[i], 1'b1, 1'b0, o);
         tests++;
         if (o.fr[9] !== 1'b1 || o.fr !== frame_of(vals[i])) begin
            fails++;
            $display("FAIL parity_%02h: got frame %b, required %b", vals[i], o.fr, frame_of(vals[i]));
         end
         tests++;
         if (!o.done_seen || o.ddelta != 1 || o.edelta != 0) begin
            fails++;
            $display("FAIL parity_done_%02h: got done=%0d err=%0d, required 1 0", vals[i], o.ddelta, o.edelta);
         end
      end
   endtask

   task automatic test_random;
      obs_t o;
      logic [7:0] d;
      for (int i = 0; i < 5; i++) begin
         d = 8'($urandom);
         run_send(d, 1'b1, 1'b0, o);
         tests++;
         if (o.fr !== frame_of(d) || !o.done_seen || o.ddelta != 1 || o.edelta != 0) begin
            fails++;
            $display("FAIL random_%02h: got frame %b done=%0d err=%0d, required %b 1 0",
                     d, o.fr, o.ddelta, o.edelta, frame_of(d));
         end
      end
   endtask

   task automatic test_nack;
      obs_t o;
      logic [7:0] d;
      int d0, e0;
      d = 8'($urandom);
      d0 = done_cnt;
      e0 = err_cnt;
      start_tx(d);
      wait_rts(o.n_inh, o.n_both, o.rts_ok);
      dev_frame(1'b0, 0, o.fr);
      repeat (10) @(negedge clk);
      tests++;
      if (o.fr !== frame_of(d)) begin
         fails++;
         $display("FAIL nack_frame: got %b, required %b", o.fr, frame_of(d));
      end
      tests++;
      if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
         fails++;
         $display("FAIL nack_pulses: got err=%0d done=%0d, required 1 0", err_cnt - e0, done_cnt - d0);
      end
      tests++;
      if (ps2clk !== 1'b1 || ps2data !== 1'b1 || tx_busy !== 1'b0) begin
         fails++;
         $display("FAIL nack_release: got clk=%b data=%b busy=%b, required 1 1 0", ps2clk, ps2data, tx_busy);
      end
   endtask

   task automatic test_timeout;
      int n_inh, n_both, n, e0, d0;
      bit ok;
      e0 = err_cnt;
      d0 = done_cnt;
      start_tx(8'($urandom));
      wait_rts(n_inh, n_both, ok);
      n = 0;
      while (tx_err !== 1'b1 && n < 700) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n != 500) begin
         fails++;
         $display("FAIL timeout_latency: got %0d cycles, required 500", n);
      end
      tests++;
      if (ps2clk !== 1'b1 || ps2data !== 1'b1) begin
         fails++;
         $display("FAIL timeout_release: got clk=%b data=%b, required 1 1", ps2clk, ps2data);
      end
      repeat (5) @(negedge clk);
      tests++;
      if (err_cnt - e0 != 1 || done_cnt - d0 != 0 || tx_busy !== 1'b0) begin
         fails++;
         $display("FAIL timeout_pulses: got err=%0d done=%0d busy=%b, required 1 0 0",
                  err_cnt - e0, done_cnt - d0, tx_busy);
      end
   endtask

   task automatic test_ignore_busy;
      obs_t o;
      int lows;
      run_send(8'hAB, 1'b1, 1'b1, o);
      tests++;
      if (o.fr !== frame_of(8'hAB) || o.ddelta != 1) begin
         fails++;
         $display("FAIL ignore_frame: got %b done=%0d, required %b 1", o.fr, o.ddelta, frame_of(8'hAB));
      end
      lows = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (ps2clk !== 1'b1 || tx_busy !== 1'b0) lows++;
      end
      tests++;
      if (lows != 0) begin
         fails++;
         $display("FAIL ignore_no_second: got %0d active cycles, required 0", lows);
      end
   endtask

   task automatic test_reset_mid;
      obs_t o;
      logic [7:0] d;
      logic [10:0] fr;
      int n_inh, n_both, d0, e0;
      bit ok;
      d = 8'($urandom) & 8'hF7;
      start_tx(d);
      wait_rts(n_inh, n_both, ok);
      dev_frame(1'b1, 4, fr);
      repeat (5) @(negedge clk);
      tests++;
      if (fr[4:0] !== {d[3:0], 1'b0} || ps2data !== 1'b0) begin
         fails++;
         $display("FAIL midreset_pre: got bits %b data=%b, required %b 0", fr[4:0], ps2data, {d[3:0], 1'b0});
      end
      d0 = done_cnt;
      e0 = err_cnt;
      reset = 1'b1;
      #1;
      tests++;
      if (ps2clk !== 1'b1 || ps2data !== 1'b1 || tx_busy !== 1'b0) begin
         fails++;
         $display("FAIL midreset_release: got clk=%b data=%b busy=%b, required 1 1 0", ps2clk, ps2data, tx_busy);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      tests++;
      if (done_cnt - d0 != 0 || err_cnt - e0 != 0) begin
         fails++;
         $display("FAIL midreset_pulses: got done=%0d err=%0d, required 0 0", done_cnt - d0, err_cnt - e0);
      end
      run_send(8'hED, 1'b1, 1'b0, o);
      tests++;
      if (o.fr !== frame_of(8'hED) || o.n_inh != 100 || o.ddelta != 1 || o.edelta != 0) begin
         fails++;
         $display("FAIL midreset_next: got frame %b inh=%0d done=%0d err=%0d, required %b 100 1 0",
                  o.fr, o.n_inh, o.ddelta, o.edelta, frame_of(8'hED));
      end
   endtask

   task automatic test_exclusive;
      tests++;
      if (both_cnt != 0) begin
         fails++;
         $display("FAIL done_err_exclusive: got %0d overlapping cycles, required 0", both_cnt);
      end
   endtask

   initial begin
      test_reset;
      test_send_f4;
      test_parity;
      test_random;
      test_nack;
      test_timeout;
      test_ignore_busy;
      test_reset_mid;
      test_exclusive;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
